// File: rtl/csr_pkg.sv
// ============================================================================
// Module      : csr_pkg
// Description : Shared types for the CSR access unit: CSR op encoding,
//               privilege levels, FSM states and a write-occurrence helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_pkg;

    localparam int CSR_ADDR_W = 12;
    localparam int CSR_DATA_W = 32;

    typedef enum logic [1:0] {
        CSR_OP_RW = 2'd0,
        CSR_OP_RS = 2'd1,
        CSR_OP_RC = 2'd2
    } csr_op_e;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'd0,
        PRIV_LVL_S = 2'd1,
        PRIV_LVL_H = 2'd2,
        PRIV_LVL_M = 2'd3
    } priv_lvl_e;

    typedef enum logic [1:0] {
        CSR_ST_IDLE  = 2'd0,
        CSR_ST_READ  = 2'd1,
        CSR_ST_WRITE = 2'd2,
        CSR_ST_RESP  = 2'd3
    } csr_access_state_e;

    // RW always writes; set/clear with an all-zero source leave the CSR alone
    function automatic logic csr_writes(input logic [1:0] op, input logic src_zero);
        return (op == CSR_OP_RW) || !src_zero;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_wdata_alu.sv
// ============================================================================
// Module      : csr_wdata_alu
// Description : Combinational read-modify-write data path. Produces the value
//               written back to the CSR from the op, the old CSR value and
//               the source operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_wdata_alu
    import csr_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] old_val,
    input  logic [31:0] src,
    output logic [31:0] wdata
);

    // Select write value: replace, set bits, or clear bits
    always_comb begin
        wdata = src;
        case (op)
            CSR_OP_RW: wdata = src;
            CSR_OP_RS: wdata = old_val | src;
            CSR_OP_RC: wdata = old_val & ~src;
            default:   wdata = src;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/csr_access_unit.sv
// ============================================================================
// Module      : csr_access_unit
// Description : Initiator for CSR register file accesses. Takes one decoded
//               CSRRW/CSRRS/CSRRC op at a time, sequences read -> modify ->
//               write against the CSR file and returns the old value to
//               writeback.
//               Optional macro CSR_ILLEGAL_CHECK_EN enables privilege and
//               read-only checks at accept time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_access_unit
    import csr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [11:0] req_addr_i,
    input  logic [31:0] req_src_i,
    input  logic        req_src_zero_i,
    input  logic        req_rd_zero_i,
    input  logic [1:0]  priv_lvl_i,
    input  logic        flush_i,
    output logic        csr_re_o,
    output logic [11:0] csr_raddr_o,
    input  logic [31:0] csr_rdata_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_illegal_o
);

    csr_access_state_e state, state_next;

    logic [1:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] src_q;
    logic [31:0] old_q;
    logic        write_q;
    logic        illegal_q;

    logic        accept;
    logic        acc_writes;
    logic        acc_reads;
    logic        acc_illegal;
    logic [31:0] alu_wdata;

    assign accept     = (state == CSR_ST_IDLE) && req_valid_i;
    assign acc_writes = csr_writes(req_op_i, req_src_zero_i);
    // RW into x0 does not need the old value, so the read is skipped
    assign acc_reads  = !((req_op_i == CSR_OP_RW) && req_rd_zero_i);

`ifdef CSR_ILLEGAL_CHECK_EN
    // Too little privilege, or a write that targets the read-only space
    assign acc_illegal = (req_addr_i[9:8] > priv_lvl_i) ||
                         ((req_addr_i[11:10] == 2'b11) && acc_writes);
`else
    logic unused_priv;
    assign unused_priv = ^priv_lvl_i;
    assign acc_illegal = 1'b0;
`endif

    csr_wdata_alu u_wdata_alu (
        .op      (op_q),
        .old_val (old_q),
        .src     (src_q),
        .wdata   (alu_wdata)
    );

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= CSR_ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the op at accept; old value starts at zero so skipped reads return 0
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            op_q      <= 2'd0;
            addr_q    <= 12'd0;
            src_q     <= 32'd0;
            old_q     <= 32'd0;
            write_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            op_q      <= req_op_i;
            addr_q    <= req_addr_i;
            src_q     <= req_src_i;
            old_q     <= 32'd0;
            write_q   <= acc_writes;
            illegal_q <= acc_illegal;
        end else if (state == CSR_ST_READ) begin
            old_q     <= csr_rdata_i;
        end
    end

    // Next-state sequencing and Moore outputs
    always_comb begin
        state_next     = state;
        req_ready_o    = 1'b0;
        csr_re_o       = 1'b0;
        csr_raddr_o    = 12'd0;
        csr_we_o       = 1'b0;
        csr_waddr_o    = 12'd0;
        csr_wdata_o    = 32'd0;
        resp_valid_o   = 1'b0;
        resp_rdata_o   = 32'd0;
        resp_illegal_o = 1'b0;

        case (state)
            CSR_ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (acc_illegal) begin
                        state_next = CSR_ST_RESP;
                    end else if (!acc_reads) begin
                        state_next = CSR_ST_WRITE;
                    end else begin
                        state_next = CSR_ST_READ;
                    end
                end
            end
            CSR_ST_READ: begin
                csr_re_o    = 1'b1;
                csr_raddr_o = addr_q;
                if (flush_i) begin
                    state_next = CSR_ST_IDLE;
                end else if (write_q) begin
                    state_next = CSR_ST_WRITE;
                end else begin
                    state_next = CSR_ST_RESP;
                end
            end
            CSR_ST_WRITE: begin
                // A flush here lets the write land but drops the response
                csr_we_o    = 1'b1;
                csr_waddr_o = addr_q;
                csr_wdata_o = alu_wdata;
                state_next  = flush_i ? CSR_ST_IDLE : CSR_ST_RESP;
            end
            CSR_ST_RESP: begin
                resp_valid_o   = 1'b1;
                resp_rdata_o   = old_q;
                resp_illegal_o = illegal_q;
                if (flush_i || resp_ready_i) begin
                    state_next = CSR_ST_IDLE;
                end
            end
            default: begin
                state_next = CSR_ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
